// File: rtl/sda_axi_lite_reg_bridge_pkg.sv
// Shared types and constants for the AXI4-Lite to register-bus bridge.
package sda_reg_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WRESP = 2'd2,
    ST_RRESP = 2'd3
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [3:0] STRB_FULL   = 4'hF;

endpackage

// File: rtl/sda_axi_lite_reg_bridge_if.sv
// AXI4-Lite control port bundle; master = host side, slave = bridge side.
interface sda_axi_lite_reg_bridge_if #(
  parameter int AxiAddrWidth = 12
);
  logic                    s_axi_awvalid;
  logic                    s_axi_awready;
  logic [AxiAddrWidth-1:0] s_axi_awaddr;
  logic                    s_axi_wvalid;
  logic                    s_axi_wready;
  logic [31:0]             s_axi_wdata;
  logic [3:0]              s_axi_wstrb;
  logic                    s_axi_bvalid;
  logic                    s_axi_bready;
  logic [1:0]              s_axi_bresp;
  logic                    s_axi_arvalid;
  logic                    s_axi_arready;
  logic [AxiAddrWidth-1:0] s_axi_araddr;
  logic                    s_axi_rvalid;
  logic                    s_axi_rready;
  logic [31:0]             s_axi_rdata;
  logic [1:0]              s_axi_rresp;

  // Every channel: a transfer happens on a cycle where valid & ready are both
  // high; valid, once raised, holds with stable payload until that transfer.
  modport master (
    output s_axi_awvalid, s_axi_awaddr, s_axi_wvalid, s_axi_wdata, s_axi_wstrb,
           s_axi_bready, s_axi_arvalid, s_axi_araddr, s_axi_rready,
    input  s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp,
           s_axi_arready, s_axi_rvalid, s_axi_rdata, s_axi_rresp
  );

  modport slave (
    input  s_axi_awvalid, s_axi_awaddr, s_axi_wvalid, s_axi_wdata, s_axi_wstrb,
           s_axi_bready, s_axi_arvalid, s_axi_araddr, s_axi_rready,
    output s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp,
           s_axi_arready, s_axi_rvalid, s_axi_rdata, s_axi_rresp
  );
endinterface

// File: rtl/sda_axi_lite_reg_bridge_timer.sv
// REQ-phase watchdog: counts enabled cycles, flags expiry at TimeoutCycles.
module sda_reg_bridge_timer #(
  parameter int TimeoutCycles = 64
) (
  input  logic clk,
  input  logic srst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CntW = 10;

  logic [CntW-1:0] cnt_q, cnt_d;

  // Expiry lands on the last REQ cycle so regReq is high exactly TimeoutCycles.
  assign expired = enable && (cnt_q == CntW'(TimeoutCycles - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear)                 cnt_d = '0;
    else if (enable && !expired) cnt_d = cnt_q + CntW'(1);
  end

  always_ff @(posedge clk) begin
    if (srst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
endmodule

// File: rtl/sda_axi_lite_reg_bridge.sv
// AXI4-Lite slave to regReq/regAck master bridge, one transaction in flight.
// Optional REQ watchdog enabled by defining SDA_REG_BRIDGE_TIMEOUT_EN.
module sda_axi_lite_reg_bridge
  import sda_reg_bridge_pkg::*;
#(
  parameter int RegAddrWidth  = 8,
  parameter int AxiAddrWidth  = 12,
  parameter int TimeoutCycles = 64
) (
  input  logic                    clk,
  input  logic                    srst,
  sda_axi_lite_reg_bridge_if.slave s_axi,
  output logic                    regReq,
  input  logic                    regAck,
  output logic                    regWriteEn,
  output logic [RegAddrWidth-1:0] regAddr,
  output logic [31:0]             regWData,
  input  logic [31:0]             regRData,
  output state_e                  dbg_state
);
  if (AxiAddrWidth < RegAddrWidth + 2) begin : g_bad_addr
    $error("AxiAddrWidth must be >= RegAddrWidth+2");
  end
  if (TimeoutCycles < 2 || TimeoutCycles > 1023) begin : g_bad_timeout
    $error("TimeoutCycles must be in 2..1023");
  end

  state_e                  state_q, state_d;
  logic [RegAddrWidth-1:0] addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    we_q, we_d;
  logic [1:0]              resp_q, resp_d;
  logic                    last_wr_q, last_wr_d;
  logic                    aw_rdy, ar_rdy;
  logic                    wr_pend, rd_pend, grant_rd;
  logic                    timeout;
  logic                    unused_ok;

  assign unused_ok = ^{s_axi.s_axi_awaddr, s_axi.s_axi_araddr};

`ifdef SDA_REG_BRIDGE_TIMEOUT_EN
  sda_reg_bridge_timer #(.TimeoutCycles(TimeoutCycles)) u_timer (
    .clk     (clk),
    .srst    (srst),
    .clear   (state_q != ST_REQ),
    .enable  (state_q == ST_REQ),
    .expired (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  assign wr_pend  = s_axi.s_axi_awvalid && s_axi.s_axi_wvalid;
  assign rd_pend  = s_axi.s_axi_arvalid;
  // last_wr_q resets to 1 so the first contested cycle goes to the read.
  assign grant_rd = rd_pend && (!wr_pend || last_wr_q);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    we_d      = we_q;
    resp_d    = resp_q;
    last_wr_d = last_wr_q;
    aw_rdy    = 1'b0;
    ar_rdy    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_rd) begin
          ar_rdy    = 1'b1;
          addr_d    = s_axi.s_axi_araddr[RegAddrWidth+1:2];
          wdata_d   = '0;
          we_d      = 1'b0;
          last_wr_d = 1'b0;
          state_d   = ST_REQ;
        end else if (wr_pend) begin
          aw_rdy    = 1'b1;
          last_wr_d = 1'b1;
          if (s_axi.s_axi_wstrb == STRB_FULL) begin
            addr_d  = s_axi.s_axi_awaddr[RegAddrWidth+1:2];
            wdata_d = s_axi.s_axi_wdata;
            we_d    = 1'b1;
            state_d = ST_REQ;
          end else begin
            // Partial writes are refused without touching the register bus.
            resp_d  = RESP_SLVERR;
            state_d = ST_WRESP;
          end
        end
      end
      ST_REQ: begin
        if (regAck) begin
          rdata_d = regRData;
          resp_d  = RESP_OKAY;
          state_d = we_q ? ST_WRESP : ST_RRESP;
        end else if (timeout) begin
          rdata_d = '0;
          resp_d  = RESP_SLVERR;
          state_d = we_q ? ST_WRESP : ST_RRESP;
        end
      end
      ST_WRESP: if (s_axi.s_axi_bready) state_d = ST_IDLE;
      ST_RRESP: if (s_axi.s_axi_rready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      we_q      <= 1'b0;
      resp_q    <= RESP_OKAY;
      last_wr_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      we_q      <= we_d;
      resp_q    <= resp_d;
      last_wr_q <= last_wr_d;
    end
  end

  assign regReq     = (state_q == ST_REQ);
  assign regWriteEn = regReq && we_q;
  assign regAddr    = regReq ? addr_q  : '0;
  assign regWData   = regReq ? wdata_q : '0;

  assign s_axi.s_axi_awready = aw_rdy;
  assign s_axi.s_axi_wready  = aw_rdy;
  assign s_axi.s_axi_arready = ar_rdy;
  assign s_axi.s_axi_bvalid  = (state_q == ST_WRESP);
  assign s_axi.s_axi_bresp   = resp_q;
  assign s_axi.s_axi_rvalid  = (state_q == ST_RRESP);
  assign s_axi.s_axi_rdata   = rdata_q;
  assign s_axi.s_axi_rresp   = resp_q;
  assign dbg_state           = state_q;
endmodule

// File: tb/tb_sda_axi_lite_reg_bridge.sv
// Directed bench for sda_axi_lite_reg_bridge; timeout scenario needs SDA_REG_BRIDGE_TIMEOUT_EN.
module tb_sda_axi_lite_reg_bridge;
  import sda_reg_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        srst = 1'b1;
  logic        regReq, regAck, regWriteEn;
  logic [7:0]  regAddr;
  logic [31:0] regWData, regRData;
  state_e      dbg_state;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] got_data;
  logic [1:0]  got_resp;

  always #5 clk = ~clk;

  sda_axi_lite_reg_bridge_if #(.AxiAddrWidth(12)) axi ();

  sda_axi_lite_reg_bridge #(
    .RegAddrWidth(8), .AxiAddrWidth(12), .TimeoutCycles(64)
  ) dut (
    .clk        (clk),
    .srst       (srst),
    .s_axi      (axi.slave),
    .regReq     (regReq),
    .regAck     (regAck),
    .regWriteEn (regWriteEn),
    .regAddr    (regAddr),
    .regWData   (regWData),
    .regRData   (regRData),
    .dbg_state  (dbg_state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    axi.s_axi_awvalid = 1'b1; axi.s_axi_awaddr = a;
    axi.s_axi_wvalid  = 1'b1; axi.s_axi_wdata  = d; axi.s_axi_wstrb = s;
  endtask

  task automatic clear_write();
    axi.s_axi_awvalid = 1'b0; axi.s_axi_wvalid = 1'b0;
  endtask

  task automatic wait_req_and_ack(input logic [31:0] d);
    int n = 0;
    while (!regReq && n < 20) begin step(); n++; end
    checks++;
    if (regReq !== 1'b1) begin
      errors++; $display("FAIL req_wait: regReq=%b expected 1", regReq);
    end
    regAck = 1'b1; regRData = d;
    step();
    regAck = 1'b0; regRData = 32'h0;
  endtask

  task automatic take_resp(output logic [31:0] d, output logic [1:0] r);
    int n = 0;
    while (!(axi.s_axi_bvalid || axi.s_axi_rvalid) && n < 20) begin step(); n++; end
    checks++;
    if (!(axi.s_axi_bvalid || axi.s_axi_rvalid)) begin
      errors++; $display("FAIL resp_wait: no bvalid/rvalid expected one");
    end
    d = axi.s_axi_rdata;
    r = axi.s_axi_rvalid ? axi.s_axi_rresp : axi.s_axi_bresp;
    axi.s_axi_bready = 1'b1; axi.s_axi_rready = 1'b1;
    step();
    axi.s_axi_bready = 1'b0; axi.s_axi_rready = 1'b0;
  endtask

  task automatic test_reset();
    srst = 1'b1;
    step(); step();
    checks++;
    if ({regReq, regWriteEn, regAddr, regWData} !== 42'h0) begin
      errors++; $display("FAIL reset_regbus: got %h expected 0", {regReq, regWriteEn, regAddr, regWData});
    end
    checks++;
    if ({axi.s_axi_bvalid, axi.s_axi_rvalid, axi.s_axi_rdata, axi.s_axi_bresp, axi.s_axi_rresp} !== 38'h0) begin
      errors++; $display("FAIL reset_axi: got %h expected 0",
        {axi.s_axi_bvalid, axi.s_axi_rvalid, axi.s_axi_rdata, axi.s_axi_bresp, axi.s_axi_rresp});
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
    end
    srst = 1'b0;
    step();
    checks++;
    if ({axi.s_axi_awready, axi.s_axi_wready, axi.s_axi_arready} !== 3'b000) begin
      errors++; $display("FAIL idle_ready: got %b expected 000",
        {axi.s_axi_awready, axi.s_axi_wready, axi.s_axi_arready});
    end
  endtask

  task automatic test_write_basic();
    drive_write(12'h000, 32'h0000_0001, 4'hF);
    #1;
    checks++;
    if ({axi.s_axi_awready, axi.s_axi_wready, axi.s_axi_arready} !== 3'b110) begin
      errors++; $display("FAIL wr_accept: got %b expected 110",
        {axi.s_axi_awready, axi.s_axi_wready, axi.s_axi_arready});
    end
    step();                       // N+1
    clear_write();
    checks++;
    if ({regReq, regWriteEn, regAddr, regWData} !== {1'b1, 1'b1, 8'h00, 32'h0000_0001}) begin
      errors++; $display("FAIL wr_regbus: got %h expected %h",
        {regReq, regWriteEn, regAddr, regWData}, {1'b1, 1'b1, 8'h00, 32'h0000_0001});
    end
    step();                       // N+2
    step();                       // N+3: ack
    regAck = 1'b1; regRData = 32'h0BAD_0BAD;
    checks++;
    if ({regReq, axi.s_axi_bvalid} !== 2'b10) begin
      errors++; $display("FAIL wr_pre_ack: got %b expected 10", {regReq, axi.s_axi_bvalid});
    end
    step();                       // N+4
    regAck = 1'b0;
    checks++;
    if ({regReq, axi.s_axi_bvalid, axi.s_axi_bresp, regWriteEn, regAddr, regWData} !==
        {1'b0, 1'b1, 2'b00, 1'b0, 8'h00, 32'h0}) begin
      errors++; $display("FAIL wr_bresp: got %h expected %h",
        {regReq, axi.s_axi_bvalid, axi.s_axi_bresp, regWriteEn, regAddr, regWData},
        {1'b0, 1'b1, 2'b00, 1'b0, 8'h00, 32'h0});
    end
    axi.s_axi_bready = 1'b1;
    step();
    axi.s_axi_bready = 1'b0;
    checks++;
    if (axi.s_axi_bvalid !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL wr_done: bvalid=%b state=%0d expected 0/IDLE", axi.s_axi_bvalid, dbg_state);
    end
  endtask

  task automatic test_read_basic();
    axi.s_axi_arvalid = 1'b1; axi.s_axi_araddr = 12'h010;
    #1;
    checks++;
    if (axi.s_axi_arready !== 1'b1) begin
      errors++; $display("FAIL rd_accept: got %b expected 1", axi.s_axi_arready);
    end
    step();
    axi.s_axi_arvalid = 1'b0;
    checks++;
    if ({regReq, regWriteEn, regAddr, regWData} !== {1'b1, 1'b0, 8'h04, 32'h0}) begin
      errors++; $display("FAIL rd_regbus: got %h expected %h",
        {regReq, regWriteEn, regAddr, regWData}, {1'b1, 1'b0, 8'h04, 32'h0});
    end
    step();
    step();
    regAck = 1'b1; regRData = 32'h1234_5678;
    step();
    regAck = 1'b0; regRData = 32'h0;
    checks++;
    if ({regReq, axi.s_axi_rvalid, axi.s_axi_rdata, axi.s_axi_rresp} !== {1'b0, 1'b1, 32'h1234_5678, 2'b00}) begin
      errors++; $display("FAIL rd_rresp: got %h expected %h",
        {regReq, axi.s_axi_rvalid, axi.s_axi_rdata, axi.s_axi_rresp}, {1'b0, 1'b1, 32'h1234_5678, 2'b00});
    end
    axi.s_axi_rready = 1'b1;
    step();
    axi.s_axi_rready = 1'b0;
    checks++;
    if (axi.s_axi_rvalid !== 1'b0) begin
      errors++; $display("FAIL rd_done: rvalid=%b expected 0", axi.s_axi_rvalid);
    end
  endtask

  task automatic test_arbitration();
    drive_write(12'h004, 32'h0000_0077, 4'hF);
    #1;
    step();
    clear_write();
    wait_req_and_ack(32'h0);
    take_resp(got_data, got_resp);
    // Last served was a write: contested cycle goes to the read.
    drive_write(12'h008, 32'h0000_00A5, 4'hF);
    axi.s_axi_arvalid = 1'b1; axi.s_axi_araddr = 12'h00C;
    #1;
    checks++;
    if ({axi.s_axi_arready, axi.s_axi_awready, axi.s_axi_wready} !== 3'b100) begin
      errors++; $display("FAIL arb_read_first: got %b expected 100",
        {axi.s_axi_arready, axi.s_axi_awready, axi.s_axi_wready});
    end
    step();
    axi.s_axi_arvalid = 1'b0;
    checks++;
    if ({regWriteEn, regAddr, axi.s_axi_awready} !== {1'b0, 8'h03, 1'b0}) begin
      errors++; $display("FAIL arb_read_bus: got %h expected %h",
        {regWriteEn, regAddr, axi.s_axi_awready}, {1'b0, 8'h03, 1'b0});
    end
    wait_req_and_ack(32'h0000_0011);
    take_resp(got_data, got_resp);
    checks++;
    if ({got_data, got_resp} !== {32'h0000_0011, 2'b00}) begin
      errors++; $display("FAIL arb_read_data: got %h expected %h", {got_data, got_resp}, {32'h0000_0011, 2'b00});
    end
    axi.s_axi_arvalid = 1'b1; axi.s_axi_araddr = 12'h014;
    #1;
    checks++;
    if ({axi.s_axi_arready, axi.s_axi_awready, axi.s_axi_wready} !== 3'b011) begin
      errors++; $display("FAIL arb_write_next: got %b expected 011",
        {axi.s_axi_arready, axi.s_axi_awready, axi.s_axi_wready});
    end
    step();
    clear_write();
    checks++;
    if ({regWriteEn, regAddr, regWData} !== {1'b1, 8'h02, 32'h0000_00A5}) begin
      errors++; $display("FAIL arb_write_bus: got %h expected %h",
        {regWriteEn, regAddr, regWData}, {1'b1, 8'h02, 32'h0000_00A5});
    end
    wait_req_and_ack(32'h0);
    take_resp(got_data, got_resp);
    #1;
    checks++;
    if (axi.s_axi_arready !== 1'b1) begin
      errors++; $display("FAIL arb_read_third: arready=%b expected 1", axi.s_axi_arready);
    end
    step();
    axi.s_axi_arvalid = 1'b0;
    wait_req_and_ack(32'h0);
    take_resp(got_data, got_resp);
  endtask

  task automatic test_strobe();
    drive_write(12'h020, 32'hFFFF_FFFF, 4'h3);
    #1;
    checks++;
    if ({axi.s_axi_awready, axi.s_axi_wready} !== 2'b11) begin
      errors++; $display("FAIL strb_accept: got %b expected 11", {axi.s_axi_awready, axi.s_axi_wready});
    end
    step();
    clear_write();
    checks++;
    if ({regReq, axi.s_axi_bvalid, axi.s_axi_bresp} !== {1'b0, 1'b1, 2'b10}) begin
      errors++; $display("FAIL strb_slverr: got %b expected 0110", {regReq, axi.s_axi_bvalid, axi.s_axi_bresp});
    end
    axi.s_axi_bready = 1'b1;
    step();
    axi.s_axi_bready = 1'b0;
    checks++;
    if ({regReq, axi.s_axi_bvalid} !== 2'b00) begin
      errors++; $display("FAIL strb_done: got %b expected 00", {regReq, axi.s_axi_bvalid});
    end
  endtask

  task automatic test_hold();
    axi.s_axi_arvalid = 1'b1; axi.s_axi_araddr = 12'h3FC;
    #1;
    step();
    axi.s_axi_arvalid = 1'b0;
    checks++;
    if (regAddr !== 8'hFF) begin
      errors++; $display("FAIL hold_top_addr: got %h expected ff", regAddr);
    end
    wait_req_and_ack(32'hCAFE_F00D);
    drive_write(12'h018, 32'h0000_0033, 4'hF);
    axi.s_axi_arvalid = 1'b1; axi.s_axi_araddr = 12'h004;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if ({axi.s_axi_rvalid, axi.s_axi_rdata, axi.s_axi_rresp, axi.s_axi_arready, axi.s_axi_awready, regReq} !==
          {1'b1, 32'hCAFE_F00D, 2'b00, 3'b000}) begin
        errors++; $display("FAIL hold_cycle%0d: got %h expected %h", i,
          {axi.s_axi_rvalid, axi.s_axi_rdata, axi.s_axi_rresp, axi.s_axi_arready, axi.s_axi_awready, regReq},
          {1'b1, 32'hCAFE_F00D, 2'b00, 3'b000});
      end
      if (i == 2) begin regAck = 1'b1; regRData = 32'h5555_5555; end
      step();
      regAck = 1'b0; regRData = 32'h0;
    end
    axi.s_axi_rready = 1'b1;
    #1;
    checks++;
    if ({axi.s_axi_arready, axi.s_axi_awready} !== 2'b00) begin
      errors++; $display("FAIL hold_handoff_ready: got %b expected 00", {axi.s_axi_arready, axi.s_axi_awready});
    end
    step();
    axi.s_axi_rready = 1'b0;
    #1;
    checks++;
    if ({axi.s_axi_rvalid, axi.s_axi_awready, axi.s_axi_arready} !== 3'b010) begin
      errors++; $display("FAIL hold_next_grant: got %b expected 010",
        {axi.s_axi_rvalid, axi.s_axi_awready, axi.s_axi_arready});
    end
    step();
    clear_write();
    wait_req_and_ack(32'h0);
    take_resp(got_data, got_resp);
    step();
    axi.s_axi_arvalid = 1'b0;
    wait_req_and_ack(32'h0000_00C4);
    take_resp(got_data, got_resp);
    checks++;
    if (got_data !== 32'h0000_00C4) begin
      errors++; $display("FAIL hold_tail_read: got %h expected 000000c4", got_data);
    end
  endtask

`ifdef SDA_REG_BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    axi.s_axi_arvalid = 1'b1; axi.s_axi_araddr = 12'h008;
    #1;
    step();
    axi.s_axi_arvalid = 1'b0;
    while (regReq && n < 200) begin n++; step(); end
    checks++;
    if (n !== 64) begin
      errors++; $display("FAIL to_cycles: got %0d expected 64", n);
    end
    checks++;
    if ({axi.s_axi_rvalid, axi.s_axi_rresp, axi.s_axi_rdata} !== {1'b1, 2'b10, 32'h0}) begin
      errors++; $display("FAIL to_rresp: got %h expected %h",
        {axi.s_axi_rvalid, axi.s_axi_rresp, axi.s_axi_rdata}, {1'b1, 2'b10, 32'h0});
    end
    take_resp(got_data, got_resp);
  endtask
`endif

  task automatic test_srst_mid_req();
    drive_write(12'h040, 32'h0000_0055, 4'hF);
    #1;
    step();
    clear_write();
    checks++;
    if (regReq !== 1'b1) begin
      errors++; $display("FAIL srst_pre: regReq=%b expected 1", regReq);
    end
    srst = 1'b1;
    step();
    srst = 1'b0;
    checks++;
    if ({regReq, regWriteEn, regAddr, regWData, axi.s_axi_bvalid, axi.s_axi_rvalid, axi.s_axi_rdata} !== 76'h0
        || dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL srst_abort: got %h state=%0d expected 0/IDLE",
        {regReq, regWriteEn, regAddr, regWData, axi.s_axi_bvalid, axi.s_axi_rvalid, axi.s_axi_rdata}, dbg_state);
    end
    regAck = 1'b1;
    step();
    regAck = 1'b0;
    step();
    checks++;
    if ({regReq, axi.s_axi_bvalid, axi.s_axi_rvalid} !== 3'b000) begin
      errors++; $display("FAIL srst_no_resp: got %b expected 000", {regReq, axi.s_axi_bvalid, axi.s_axi_rvalid});
    end
    drive_write(12'h000, 32'h1, 4'hF);
    axi.s_axi_arvalid = 1'b1; axi.s_axi_araddr = 12'h000;
    #1;
    checks++;
    if ({axi.s_axi_arready, axi.s_axi_awready} !== 2'b10) begin
      errors++; $display("FAIL srst_read_first: got %b expected 10", {axi.s_axi_arready, axi.s_axi_awready});
    end
    clear_write();
    axi.s_axi_arvalid = 1'b0;
    step();
  endtask

  initial begin
    axi.s_axi_awvalid = 1'b0; axi.s_axi_awaddr = '0;
    axi.s_axi_wvalid  = 1'b0; axi.s_axi_wdata  = '0; axi.s_axi_wstrb = '0;
    axi.s_axi_bready  = 1'b0;
    axi.s_axi_arvalid = 1'b0; axi.s_axi_araddr = '0;
    axi.s_axi_rready  = 1'b0;
    regAck = 1'b0; regRData = '0;
    test_reset();
    test_write_basic();
    test_read_basic();
    test_arbitration();
    test_strobe();
    test_hold();
`ifdef SDA_REG_BRIDGE_TIMEOUT_EN
    test_timeout();
`endif
    test_srst_mid_req();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
